// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronizes board reset and PLL lock, then releases the
// peripheral, memory and core reset domains in order with timed gaps.
// A software warm-reset request re-asserts every domain and re-runs the release.
module rst_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int SOFT_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       i_aclk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_soft_rst_req,
  output logic       o_periph_rst_n,
  output logic       o_mem_rst_n,
  output logic       o_core_rst_n,
  output logic       o_rst_done,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_SYNC       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_REL_PERIPH = 3'd3,
    ST_REL_MEM    = 3'd4,
    ST_REL_CORE   = 3'd5,
    ST_RUN        = 3'd6,
    ST_SOFT       = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SOFT_LOAD = CNT_W'(SOFT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   rst_s;
  logic                   lock_s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   cnt_zero;
  logic                   in_seq;

  assign rst_s    = rst_sync[SYNC_STAGES-1];
  assign lock_s   = lock_sync[SYNC_STAGES-1];
  assign cnt_zero = (cnt == '0);
  // States from HOLD onward are the ones that lock loss can abort.
  assign in_seq   = (state != ST_SYNC) && (state != ST_WAIT_LOCK);
  assign o_state  = state;

  // Reset-deassert and PLL-lock synchronizer chains, cleared asynchronously.
  always_ff @(posedge i_aclk or negedge i_rst) begin
    if (!i_rst) begin
      rst_sync  <= '0;
      lock_sync <= '0;
    end else begin
      rst_sync  <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], i_pll_locked};
    end
  end

  // Sequencing FSM with shared down-counter and registered domain resets.
  always_ff @(posedge i_aclk or negedge i_rst) begin
    if (!i_rst) begin
      state          <= ST_SYNC;
      cnt            <= '0;
      o_periph_rst_n <= 1'b0;
      o_mem_rst_n    <= 1'b0;
      o_core_rst_n   <= 1'b0;
      o_rst_done     <= 1'b0;
    end else if (in_seq && !lock_s) begin
      // Lock loss beats soft requests and counter expiry.
      state          <= ST_WAIT_LOCK;
      cnt            <= '0;
      o_periph_rst_n <= 1'b0;
      o_mem_rst_n    <= 1'b0;
      o_core_rst_n   <= 1'b0;
      o_rst_done     <= 1'b0;
    end else begin
      if (!cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end
      case (state)
        ST_SYNC: begin
          if (rst_s) begin
            state <= ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_HOLD;
            cnt   <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            state          <= ST_REL_PERIPH;
            o_periph_rst_n <= 1'b1;
            cnt            <= GAP_LOAD;
          end
        end
        ST_REL_PERIPH: begin
          if (cnt_zero) begin
            state       <= ST_REL_MEM;
            o_mem_rst_n <= 1'b1;
            cnt         <= GAP_LOAD;
          end
        end
        ST_REL_MEM: begin
          if (cnt_zero) begin
            state        <= ST_REL_CORE;
            o_core_rst_n <= 1'b1;
            o_rst_done   <= 1'b1;
          end
        end
        ST_REL_CORE: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (i_soft_rst_req) begin
            state          <= ST_SOFT;
            cnt            <= SOFT_LOAD;
            o_periph_rst_n <= 1'b0;
            o_mem_rst_n    <= 1'b0;
            o_core_rst_n   <= 1'b0;
            o_rst_done     <= 1'b0;
          end
        end
        ST_SOFT: begin
          if (cnt_zero) begin
            state <= ST_HOLD;
            cnt   <= HOLD_LOAD;
          end
        end
        default: begin
          state <= ST_SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: stimulus queues the expected output
// transitions (edge number and output vector); a negedge monitor pops one
// entry every time the DUT output vector changes and compares it.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_req;
  logic       periph_rst_n, mem_rst_n, core_rst_n, rst_done;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;

  typedef struct {
    int         edge_n;
    logic [6:0] vec;
  } exp_t;

  exp_t       sbq[$];
  logic [6:0] prev_vec = 7'd0;
  logic [6:0] mon_vec;
  exp_t       head;

  rst_sequencer dut (
    .i_aclk         (clk),
    .i_rst          (rst_n),
    .i_pll_locked   (pll_locked),
    .i_soft_rst_req (soft_req),
    .o_periph_rst_n (periph_rst_n),
    .o_mem_rst_n    (mem_rst_n),
    .o_core_rst_n   (core_rst_n),
    .o_rst_done     (rst_done),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [6:0] cur_vec();
    return {state, periph_rst_n, mem_rst_n, core_rst_n, rst_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) tick();
  endtask

  task automatic push(input int e, input logic [2:0] st, input logic [3:0] o);
    exp_t x;
    x.edge_n = e;
    x.vec    = {st, o};
    sbq.push_back(x);
  endtask

  // Release of the three domains after HOLD is entered at edge h.
  task automatic release_seq(input int h);
    push(h + 16, 3'd3, 4'b1000);
    push(h + 20, 3'd4, 4'b1100);
    push(h + 24, 3'd5, 4'b1111);
    push(h + 25, 3'd6, 4'b1111);
  endtask

  // Full sequence after i_rst is released between edge r and r+1, lock high.
  task automatic startup(input int r);
    push(r + 3, 3'd1, 4'b0000);
    push(r + 4, 3'd2, 4'b0000);
    release_seq(r + 4);
  endtask

  task automatic chk_zero(input string nm);
    tests++;
    if (cur_vec() !== 7'd0) begin
      fails++;
      $display("FAIL %s: outputs %b, required 0000000", nm, cur_vec());
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d expected transitions pending, required 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor: every output change must match the next queued transition.
  always @(negedge clk) begin
    mon_vec = cur_vec();
    if (mon_vec !== prev_vec) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: edge %0d outputs %b, required no change from %b",
                 edge_cnt, mon_vec, prev_vec);
      end else begin
        head = sbq.pop_front();
        if (head.edge_n != edge_cnt || head.vec !== mon_vec) begin
          fails++;
          $display("FAIL transition: edge %0d outputs %b, required edge %0d outputs %b",
                   edge_cnt, mon_vec, head.edge_n, head.vec);
        end
      end
      prev_vec = mon_vec;
    end
    if (sbq.size() != 0 && sbq[0].edge_n < edge_cnt) begin
      tests++;
      fails++;
      $display("FAIL missed_transition: edge %0d outputs %b, required edge %0d outputs %b",
               edge_cnt, mon_vec, sbq[0].edge_n, sbq[0].vec);
      void'(sbq.pop_front());
    end
    tests++;
    if ((core_rst_n && !mem_rst_n) || (mem_rst_n && !periph_rst_n)) begin
      fails++;
      $display("FAIL release_order: p/m/c %b%b%b, required ordered release",
               periph_rst_n, mem_rst_n, core_rst_n);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    soft_req   = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_values");

    // Power-up with lock already present.
    startup(0);
    #1 rst_n = 1'b1;
    drain("powerup");

    // Soft reset in RUN, a repeat request in SOFT and one in HOLD are ignored.
    e = edge_cnt;
    push(e + 1, 3'd7, 4'b0000);
    push(e + 9, 3'd2, 4'b0000);
    release_seq(e + 9);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    wait_until(e + 4);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    wait_until(e + 12);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    drain("soft");

    // Lock loss while in REL_MEM, then lock returns.
    e = edge_cnt;
    push(e + 1, 3'd7, 4'b0000);
    push(e + 9, 3'd2, 4'b0000);
    push(e + 25, 3'd3, 4'b1000);
    push(e + 29, 3'd4, 4'b1100);
    push(e + 32, 3'd1, 4'b0000);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    wait_until(e + 29);
    pll_locked = 1'b0;
    wait_until(e + 41);
    push(e + 44, 3'd2, 4'b0000);
    release_seq(e + 44);
    pll_locked = 1'b1;
    drain("lock_loss");

    // Async reset from RUN with late lock (50 cycles after reset release).
    e = edge_cnt;
    push(e, 3'd0, 4'b0000);
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #1 chk_zero("async_run_latelock");
    wait_until(e + 2);
    push(e + 5, 3'd1, 4'b0000);
    rst_n = 1'b1;
    wait_until(e + 52);
    push(e + 55, 3'd2, 4'b0000);
    release_seq(e + 55);
    pll_locked = 1'b1;
    drain("late_lock");

    // Async reset in RUN, then again mid-HOLD.
    e = edge_cnt;
    push(e, 3'd0, 4'b0000);
    rst_n = 1'b0;
    #1 chk_zero("async_run");
    wait_until(e + 2);
    push(e + 5, 3'd1, 4'b0000);
    push(e + 6, 3'd2, 4'b0000);
    rst_n = 1'b1;
    wait_until(e + 12);
    push(e + 12, 3'd0, 4'b0000);
    rst_n = 1'b0;
    #1 chk_zero("async_hold");
    wait_until(e + 14);
    startup(e + 14);
    rst_n = 1'b1;
    drain("async_hold");

    // Lock loss and soft request on the same edge: lock loss wins.
    e = edge_cnt;
    pll_locked = 1'b0;
    wait_until(e + 2);
    push(e + 3, 3'd1, 4'b0000);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    wait_until(e + 6);
    push(e + 9, 3'd2, 4'b0000);
    release_seq(e + 9);
    pll_locked = 1'b1;
    drain("lock_vs_soft");

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
